csr_access_unit: RTL and testbench

//   Initiator side of the CSR port: executes Zicsr instructions (CSRRW/S/C, CSRRWI/SI/CI) from the execute stage.

---
 rtl/csr_access_unit_pkg.sv | 57 +++++
 rtl/csr_access_unit_if.sv | 28 ++
 rtl/csr_access_unit.sv | 186 ++++++++++++++++++
 tb/tb_csr_access_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/csr_access_unit_pkg.sv
// Shared types, CSR address map and the read-modify-write helper for the
// CSR access unit and the register file it drives.
package csr_access_unit_pkg;

  localparam int XLEN = 32;

  // Encodings follow funct3[1:0] of the Zicsr instructions.
  typedef enum logic [1:0] {
    CSR_RW = 2'b01,
    CSR_RS = 2'b10,
    CSR_RC = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_ACCESS       = 3'd1,
    ST_CAPTURE      = 3'd2,
    ST_WRITE        = 3'd3,
    ST_RESP         = 3'd4,
    ST_ILLEGAL_RESP = 3'd5
  } csr_state_e;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // Address bits [11:10] == 2'b11 mark the read-only CSR space.
  localparam logic [1:0] CSR_RO_SPACE = 2'b11;

  function automatic csr_op_e decode_op(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b10:   decode_op = CSR_RS;
      2'b11:   decode_op = CSR_RC;
      default: decode_op = CSR_RW;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] csr_modify(input csr_op_e op,
                                                 input logic [XLEN-1:0] old_val,
                                                 input logic [XLEN-1:0] operand);
    case (op)
      CSR_RW:  csr_modify = operand;
      CSR_RS:  csr_modify = old_val | operand;
      CSR_RC:  csr_modify = old_val & ~operand;
      default: csr_modify = old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Request/response handshake between the execute stage (master) and the
// CSR access unit (slave).
interface csr_access_unit_if;
  import csr_access_unit_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [2:0]      funct3;
  logic [11:0]     csr_addr;
  logic [4:0]      rs1_idx;
  logic [XLEN-1:0] rs1_data;
  logic [4:0]      rd_idx;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_illegal;

  modport master (
    output req_valid, funct3, csr_addr, rs1_idx, rs1_data, rd_idx, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_illegal
  );

  modport slave (
    input  req_valid, funct3, csr_addr, rs1_idx, rs1_data, rd_idx, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_illegal
  );

endinterface

// File: rtl/csr_access_unit.sv
// Initiator side of the CSR port: sequences Zicsr read/modify/write against a
// register file with one-cycle registered read data. All outputs are flops.
module csr_access_unit
  import csr_access_unit_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  csr_access_unit_if.slave req_if,
  output logic             csr_rd_en_o,
  output logic             csr_wr_en_o,
  output logic [11:0]      csr_idx_o,
  output logic [XLEN-1:0]  csr_wdata_o,
  input  logic [XLEN-1:0]  csr_rdata_i
);

  csr_state_e      state_q, state_d;
  csr_op_e         op_q, op_d;
  logic [11:0]     addr_q, addr_d;
  logic [XLEN-1:0] operand_q, operand_d;
  logic            do_read_q, do_read_d;
  logic            do_write_q, do_write_d;
  logic [XLEN-1:0] old_q, old_d;

  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_illegal_q, resp_illegal_d;
  logic            csr_rd_en_q, csr_rd_en_d;
  logic            csr_wr_en_q, csr_wr_en_d;
  logic [11:0]     csr_idx_q, csr_idx_d;
  logic [XLEN-1:0] csr_wdata_q, csr_wdata_d;

  csr_op_e         op_s;
  logic            do_read_s;
  logic            do_write_s;
  logic            illegal_s;
  logic [XLEN-1:0] operand_s;
  logic [XLEN-1:0] capt_old_s;
  logic            accept_s;

  // Instruction decode of the presented request.
  always_comb begin
    op_s       = decode_op(req_if.funct3[1:0]);
    do_write_s = (req_if.funct3[1:0] == 2'b01) || (req_if.rs1_idx != 5'd0);
    do_read_s  = (req_if.funct3[1:0] != 2'b01) || (req_if.rd_idx != 5'd0);
    illegal_s  = (req_if.funct3[1:0] == 2'b00) ||
                 (do_write_s && (req_if.csr_addr[11:10] == CSR_RO_SPACE));
    operand_s  = req_if.funct3[2] ? {{(XLEN-5){1'b0}}, req_if.rs1_idx} : req_if.rs1_data;
    accept_s   = req_if.req_valid && req_ready_q;
    capt_old_s = do_read_q ? csr_rdata_i : {XLEN{1'b0}};
  end

  // Next state and next registered outputs; CSR strobes default to idle each cycle.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    operand_d      = operand_q;
    do_read_d      = do_read_q;
    do_write_d     = do_write_q;
    old_d          = old_q;
    req_ready_d    = req_ready_q;
    resp_valid_d   = resp_valid_q;
    resp_rdata_d   = resp_rdata_q;
    resp_illegal_d = resp_illegal_q;
    csr_rd_en_d    = 1'b0;
    csr_wr_en_d    = 1'b0;
    csr_idx_d      = 12'd0;
    csr_wdata_d    = {XLEN{1'b0}};

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d        = op_s;
          addr_d      = req_if.csr_addr;
          operand_d   = operand_s;
          do_read_d   = do_read_s;
          do_write_d  = do_write_s;
          old_d       = {XLEN{1'b0}};
          req_ready_d = 1'b0;
          if (illegal_s) begin
            state_d        = ST_ILLEGAL_RESP;
            resp_valid_d   = 1'b1;
            resp_illegal_d = 1'b1;
            resp_rdata_d   = {XLEN{1'b0}};
          end else begin
            // RW drives both strobes together: the file performs an atomic swap.
            state_d     = ST_ACCESS;
            csr_rd_en_d = do_read_s;
            csr_wr_en_d = (op_s == CSR_RW);
            csr_idx_d   = req_if.csr_addr;
            csr_wdata_d = operand_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        old_d = capt_old_s;
        if ((op_q != CSR_RW) && do_write_q) begin
          state_d     = ST_WRITE;
          csr_wr_en_d = 1'b1;
          csr_idx_d   = addr_q;
          csr_wdata_d = csr_modify(op_q, capt_old_s, operand_q);
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = capt_old_s;
        end
      end
      ST_WRITE: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = old_q;
      end
      ST_RESP, ST_ILLEGAL_RESP: begin
        if (req_if.resp_ready) begin
          state_d        = ST_IDLE;
          req_ready_d    = 1'b1;
          resp_valid_d   = 1'b0;
          resp_illegal_d = 1'b0;
          resp_rdata_d   = {XLEN{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d        = ST_IDLE;
        req_ready_d    = 1'b1;
        resp_valid_d   = 1'b0;
        resp_illegal_d = 1'b0;
        resp_rdata_d   = {XLEN{1'b0}};
      end
    endcase
  end

  // State, latched instruction fields and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      op_q           <= CSR_RW;
      addr_q         <= 12'd0;
      operand_q      <= {XLEN{1'b0}};
      do_read_q      <= 1'b0;
      do_write_q     <= 1'b0;
      old_q          <= {XLEN{1'b0}};
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= {XLEN{1'b0}};
      resp_illegal_q <= 1'b0;
      csr_rd_en_q    <= 1'b0;
      csr_wr_en_q    <= 1'b0;
      csr_idx_q      <= 12'd0;
      csr_wdata_q    <= {XLEN{1'b0}};
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      addr_q         <= addr_d;
      operand_q      <= operand_d;
      do_read_q      <= do_read_d;
      do_write_q     <= do_write_d;
      old_q          <= old_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_illegal_q <= resp_illegal_d;
      csr_rd_en_q    <= csr_rd_en_d;
      csr_wr_en_q    <= csr_wr_en_d;
      csr_idx_q      <= csr_idx_d;
      csr_wdata_q    <= csr_wdata_d;
    end
  end

  assign req_if.req_ready    = req_ready_q;
  assign req_if.resp_valid   = resp_valid_q;
  assign req_if.resp_rdata   = resp_rdata_q;
  assign req_if.resp_illegal = resp_illegal_q;
  assign csr_rd_en_o         = csr_rd_en_q;
  assign csr_wr_en_o         = csr_wr_en_q;
  assign csr_idx_o           = csr_idx_q;
  assign csr_wdata_o         = csr_wdata_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed plus randomized bench for csr_access_unit, with a register-file
// responder and an instruction-level reference model of CSR contents.
module tb_csr_access_unit;
  import csr_access_unit_pkg::*;

  logic             clk;
  logic             rst_ni;
  logic             csr_rd_en;
  logic             csr_wr_en;
  logic [11:0]      csr_idx;
  logic [XLEN-1:0]  csr_wdata;
  logic [XLEN-1:0]  file_rdata;

  csr_access_unit_if bus();

  csr_access_unit dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_if      (bus.slave),
    .csr_rd_en_o (csr_rd_en),
    .csr_wr_en_o (csr_wr_en),
    .csr_idx_o   (csr_idx),
    .csr_wdata_o (csr_wdata),
    .csr_rdata_i (file_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Register-file responder: registered read data, write-after-read swap.
  logic [31:0] file_mem [0:4095];
  logic [31:0] ref_mem  [0:4095];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (csr_rd_en) file_rdata <= file_mem[csr_idx];
    if (csr_wr_en) file_mem[csr_idx] <= csr_wdata;
    if (pl_en)     file_mem[pl_addr] <= pl_data;
  end

  // Strobe monitor, sampled away from the active edge.
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, idle_bad = 0;
  logic [31:0] last_wdata;
  always @(negedge clk) begin
    if (csr_rd_en) rd_cnt <= rd_cnt + 1;
    if (csr_wr_en) begin
      wr_cnt     <= wr_cnt + 1;
      last_wdata <= csr_wdata;
    end
    if (csr_rd_en && csr_wr_en) both_cnt <= both_cnt + 1;
    if (!csr_rd_en && !csr_wr_en && (csr_idx != 12'd0 || csr_wdata != 32'd0))
      idle_bad <= idle_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic run_txn(input logic [2:0] f3, input logic [11:0] addr,
                         input logic [4:0] rs1i, input logic [31:0] rs1d,
                         input logic [4:0] rdi, input int bp);
    logic [1:0]  op;
    logic        rd_f, wr_f, ill;
    logic [31:0] opnd, exp_old, held;
    int          exp_lat, lat, rd0, wr0, both0, idle0, w;
    op      = f3[1:0];
    opnd    = f3[2] ? {27'd0, rs1i} : rs1d;
    wr_f    = (op == 2'b01) || (rs1i != 5'd0);
    rd_f    = (op != 2'b01) || (rdi != 5'd0);
    ill     = (op == 2'b00) || (wr_f && addr[11:10] == 2'b11);
    exp_old = (!ill && rd_f) ? ref_mem[addr] : 32'd0;
    exp_lat = ill ? 1 : ((op != 2'b01 && wr_f) ? 4 : 3);
    if (!ill && wr_f) begin
      if (op == 2'b01)      ref_mem[addr] = opnd;
      else if (op == 2'b10) ref_mem[addr] = ref_mem[addr] | opnd;
      else                  ref_mem[addr] = ref_mem[addr] & ~opnd;
    end

    @(negedge clk);
    w = 0;
    while (!bus.req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_before_accept", {31'd0, bus.req_ready}, 32'd1);
    rd0 = rd_cnt; wr0 = wr_cnt; both0 = both_cnt; idle0 = idle_bad;
    bus.req_valid = 1'b1; bus.funct3 = f3; bus.csr_addr = addr;
    bus.rs1_idx = rs1i; bus.rs1_data = rs1d; bus.rd_idx = rdi;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;

    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid) break;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_rdata", bus.resp_rdata, exp_old);
    check("resp_illegal", {31'd0, bus.resp_illegal}, {31'd0, ill});
    check("rd_en_cycles", 32'(rd_cnt - rd0), (!ill && rd_f) ? 32'd1 : 32'd0);
    check("wr_en_cycles", 32'(wr_cnt - wr0), (!ill && wr_f) ? 32'd1 : 32'd0);
    check("swap_cycles", 32'(both_cnt - both0), (!ill && rd_f && op == 2'b01) ? 32'd1 : 32'd0);

    held = bus.resp_rdata;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      check("bp_rdata_held", bus.resp_rdata, held);
      check("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    check("post_hs_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("post_hs_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("csr_contents", file_mem[addr], ref_mem[addr]);
    check("idle_strobes_clean", 32'(idle_bad - idle0), 32'd0);
  endtask

  logic [11:0] addr_list [0:7];
  logic [2:0]  rf3;
  logic [4:0]  rrs1, rrd;
  logic [11:0] raddr;
  int          w;

  initial begin
    addr_list[0] = 12'h300; addr_list[1] = 12'h305; addr_list[2] = 12'h340;
    addr_list[3] = 12'h341; addr_list[4] = 12'hC00; addr_list[5] = 12'hF11;
    addr_list[6] = 12'hF14; addr_list[7] = 12'h7C0;
    rst_ni = 1'b0; pl_en = 1'b0; pl_addr = 12'd0; pl_data = 32'd0;
    bus.req_valid = 1'b0; bus.funct3 = 3'd0; bus.csr_addr = 12'd0;
    bus.rs1_idx = 5'd0; bus.rs1_data = 32'd0; bus.rd_idx = 5'd0; bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_rd_wr_en", {30'd0, csr_rd_en, csr_wr_en}, 32'd0);
    check("rst_idx_wdata", {20'd0, csr_idx} | csr_wdata, 32'd0);
    rst_ni = 1'b1;

    for (int i = 0; i < 8; i++) preload(addr_list[i], $urandom);

    // Directed cases.
    preload(12'h300, 32'h0000_0008);
    run_txn(3'b001, 12'h300, 5'd7, 32'hDEAD_BEEF, 5'd5, 0);
    check("mstatus_after_rw", file_mem[12'h300], 32'hDEAD_BEEF);
    preload(12'h300, 32'h0000_0001);
    run_txn(3'b010, 12'h300, 5'd3, 32'h0000_0088, 5'd4, 0);
    check("rs_wdata", last_wdata, 32'h0000_0089);
    run_txn(3'b111, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd6, 0);
    run_txn(3'b001, 12'h340, 5'd9, 32'h1234_5678, 5'd0, 0);
    run_txn(3'b001, 12'hF11, 5'd1, 32'h5555_AAAA, 5'd2, 0);
    run_txn(3'b100, 12'h300, 5'd1, 32'h1, 5'd2, 0);
    run_txn(3'b000, 12'h305, 5'd0, 32'h1, 5'd0, 0);
    run_txn(3'b010, 12'hF11, 5'd0, 32'hFFFF_FFFF, 5'd8, 0);
    run_txn(3'b110, 12'h341, 5'd21, 32'd0, 5'd1, 5);
    run_txn(3'b101, 12'h305, 5'd0, 32'd0, 5'd3, 5);

    // Reset asserted while the RS write strobe is on the bus.
    preload(12'h300, 32'h0000_0010);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.funct3 = 3'b010; bus.csr_addr = 12'h300;
    bus.rs1_idx = 5'd2; bus.rs1_data = 32'h0000_0003; bus.rd_idx = 5'd1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    w = 0;
    while (!csr_wr_en && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("midwrite_wr_en_seen", {31'd0, csr_wr_en}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check("midwrite_wr_en_drop", {31'd0, csr_wr_en}, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("midwrite_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("midwrite_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("midwrite_csr_unchanged", file_mem[12'h300], ref_mem[12'h300]);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 40; t++) begin
      raddr = addr_list[$urandom_range(0, 7)];
      rf3   = 3'($urandom_range(0, 7));
      rrs1  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rrd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_txn(rf3, raddr, rrs1, $urandom, rrd, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
